vdp_cpu_port: RTL and testbench

CPU-side port of the MSX video subsystem: decodes Z80 I/O accesses to the VDP data port (0x98) and control port (0x99). Implements the TMS9918 two-byte control sequence, the 14-bit auto-incrementing VRAM address, the read-ahead buffer, VDP register writes, and the status/interrupt flag. It drives the CPU-side VRAM port of the video generator and supplies its mode, table base and enable inputs.

---
 rtl/vdp_cpu_port_if.sv | 33 +++
 rtl/vdp_cpu_port.sv | 160 ++++++++++++++++
 tb/tb_vdp_cpu_port.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vdp_cpu_port_if.sv
// Bundles the Z80-side strobes, VRAM port A and video-generator control lines of the VDP CPU port.
// The slave modport belongs to the port logic; the master modport belongs to the surrounding system.
interface vdp_cpu_port_if;
   logic        cpu_wr;
   logic        cpu_rd;
   logic        cpu_a0;
   logic [7:0]  cpu_din;
   logic [7:0]  cpu_dout;
   logic [13:0] vram_addr;
   logic [7:0]  vram_dout;
   logic [7:0]  vram_din;
   logic        vram_wr;
   logic        vram_rd;
   logic        vblank_n;
   logic        n_int;
   logic [1:0]  mode;
   logic [13:0] name_table_addr;
   logic [13:0] font_addr;
   logic        video_on;
   logic        busy;

   modport slave (
      input  cpu_wr, cpu_rd, cpu_a0, cpu_din, vram_din, vblank_n,
      output cpu_dout, vram_addr, vram_dout, vram_wr, vram_rd, n_int,
             mode, name_table_addr, font_addr, video_on, busy
   );

   modport master (
      output cpu_wr, cpu_rd, cpu_a0, cpu_din, vram_din, vblank_n,
      input  cpu_dout, vram_addr, vram_dout, vram_wr, vram_rd, n_int,
             mode, name_table_addr, font_addr, video_on, busy
   );
endinterface

// File: rtl/vdp_cpu_port.sv
// TMS9918-style CPU port: control byte pairs, auto-incrementing VRAM address, read-ahead buffer, registers.
// Define VDP_INT_EN to build the status flag, vblank edge detector and interrupt output.
module vdp_cpu_port (
   input  logic            clk,
   input  logic            reset,
   vdp_cpu_port_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, REQ, CAP} state_t;

   state_t           state_q, state_d;
   logic [13:0]      addr_q, addr_d;
   logic [13:0]      vramAddr_q, vramAddr_d;
   logic [7:0]       latch_q, latch_d;
   logic [7:0]       readBuf_q, readBuf_d;
   logic [7:0]       cpuDout_q, cpuDout_d;
   logic [7:0]       vramDout_q, vramDout_d;
   logic             toggle_q, toggle_d;
   logic             vramWr_q, vramWr_d;
   logic [7:0][7:0]  regs_q, regs_d;
   logic             wrStrobe, rdStrobe, statusRd;
   logic [7:0]       statusByte;

   // Strobes that land during a prefetch are dropped completely.
   assign wrStrobe = bus.cpu_wr && (state_q == IDLE);
   assign rdStrobe = bus.cpu_rd && (state_q == IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         vramAddr_q <= '0;
         latch_q    <= '0;
         readBuf_q  <= '0;
         cpuDout_q  <= '0;
         vramDout_q <= '0;
         toggle_q   <= 1'b0;
         vramWr_q   <= 1'b0;
         regs_q     <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         vramAddr_q <= vramAddr_d;
         latch_q    <= latch_d;
         readBuf_q  <= readBuf_d;
         cpuDout_q  <= cpuDout_d;
         vramDout_q <= vramDout_d;
         toggle_q   <= toggle_d;
         vramWr_q   <= vramWr_d;
         regs_q     <= regs_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      vramAddr_d = vramAddr_q;
      latch_d    = latch_q;
      readBuf_d  = readBuf_q;
      cpuDout_d  = cpuDout_q;
      vramDout_d = vramDout_q;
      toggle_d   = toggle_q;
      vramWr_d   = 1'b0;
      regs_d     = regs_q;
      statusRd   = 1'b0;

      unique case (state_q)
         IDLE: state_d = IDLE;
         REQ:  state_d = CAP;
         CAP: begin
            readBuf_d = bus.vram_din;
            addr_d    = addr_q + 14'd1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (wrStrobe) begin
         if (bus.cpu_a0) begin
            if (!toggle_q) begin
               latch_d  = bus.cpu_din;
               toggle_d = 1'b1;
            end else begin
               toggle_d = 1'b0;
               if (bus.cpu_din[7]) begin
                  regs_d[bus.cpu_din[2:0]] = latch_q;
               end else begin
                  addr_d = {bus.cpu_din[5:0], latch_q};
                  // A read setup primes the buffer from the freshly loaded address.
                  if (!bus.cpu_din[6]) begin
                     vramAddr_d = {bus.cpu_din[5:0], latch_q};
                     state_d    = REQ;
                  end
               end
            end
         end else begin
            vramAddr_d = addr_q;
            vramDout_d = bus.cpu_din;
            vramWr_d   = 1'b1;
            readBuf_d  = bus.cpu_din;
            addr_d     = addr_q + 14'd1;
            toggle_d   = 1'b0;
         end
      end else if (rdStrobe) begin
         toggle_d = 1'b0;
         if (bus.cpu_a0) begin
            cpuDout_d = statusByte;
            statusRd  = 1'b1;
         end else begin
            cpuDout_d  = readBuf_q;
            vramAddr_d = addr_q;
            state_d    = REQ;
         end
      end
   end

`ifdef VDP_INT_EN
   logic flag_q, flag_d, vblankPrev_q, vblankFall, unusedRegs;

   assign vblankFall = vblankPrev_q && !bus.vblank_n;

   // A frame edge coinciding with a status read keeps the flag set.
   always_comb begin
      flag_d = flag_q;
      if (statusRd)   flag_d = 1'b0;
      if (vblankFall) flag_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flag_q       <= 1'b0;
         vblankPrev_q <= 1'b1;
      end else begin
         flag_q       <= flag_d;
         vblankPrev_q <= bus.vblank_n;
      end
   end

   assign statusByte = {flag_q, 7'b0};
   assign bus.n_int  = !(flag_q && regs_q[1][5]);
   assign unusedRegs = ^regs_q;
`else
   logic unusedRegs;
   assign statusByte = 8'h00;
   assign bus.n_int  = 1'b1;
   assign unusedRegs = ^{regs_q, bus.vblank_n, statusRd};
`endif

   assign bus.cpu_dout        = cpuDout_q;
   assign bus.vram_addr       = vramAddr_q;
   assign bus.vram_dout       = vramDout_q;
   assign bus.vram_wr         = vramWr_q;
   assign bus.vram_rd         = (state_q == REQ);
   assign bus.busy            = (state_q != IDLE);
   assign bus.mode            = regs_q[1][4] ? 2'b00 : (regs_q[0][1] ? 2'b10 : 2'b01);
   assign bus.name_table_addr = {regs_q[2][3:0], 10'b0};
   assign bus.font_addr       = {regs_q[4][2:0], 11'b0};
   assign bus.video_on        = regs_q[1][6];

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Scoreboard bench for vdp_cpu_port: a behavioural VDP model predicts VRAM writes and CPU read data,
// while independent monitors compare whatever the port actually presents.
module tb_vdp_cpu_port;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vdp_cpu_port_if bus ();

   vdp_cpu_port dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [13:0] addr;
      logic [7:0]  data;
   } wrExp_t;

   wrExp_t      wrQ[$];
   logic [7:0]  rdQ[$];
   int          errors = 0;
   int          checks = 0;

   bit   [7:0]  vram [16384];
   bit   [7:0]  refMem [16384];
   logic        preloadEn = 1'b0;
   logic [13:0] preloadAddr = '0;
   logic [7:0]  preloadData = '0;

   logic [13:0] mAddr;
   logic [7:0]  mLatch, mBuf;
   logic [7:0]  mRegs [8];
   bit          mToggle, mF;
   logic        rdSeen = 1'b0;

   // Synchronous VRAM behind port A, with a side door for preloading contents.
   always @(posedge clk) begin
      if (preloadEn) vram[preloadAddr] <= preloadData;
      if (bus.vram_wr) vram[bus.vram_addr] <= bus.vram_dout;
      if (bus.vram_rd) bus.vram_din <= vram[bus.vram_addr];
   end

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Every VRAM write pulse must match the oldest predicted write.
   always @(negedge clk) begin
      if (bus.vram_wr === 1'b1) begin
         if (wrQ.size() == 0) begin
            checkOutput("unexpected vram_wr", 16'd1, 16'd0);
         end else begin
            wrExp_t e;
            e = wrQ.pop_front();
            checkOutput("vram_wr addr", {2'b0, bus.vram_addr}, {2'b0, e.addr});
            checkOutput("vram_wr data", {8'b0, bus.vram_dout}, {8'b0, e.data});
         end
      end
   end

   // Every accepted read strobe must be followed by the oldest predicted read value.
   always @(posedge clk) rdSeen <= bus.cpu_rd;
   always @(negedge clk) begin
      if (rdSeen) begin
         if (rdQ.size() == 0) checkOutput("unexpected read", 16'd1, 16'd0);
         else checkOutput("cpu_dout", {8'b0, bus.cpu_dout}, {8'b0, rdQ.pop_front()});
      end
   end

   task automatic modelReset();
      mAddr = '0; mLatch = '0; mBuf = '0; mToggle = 0; mF = 0;
      for (int i = 0; i < 8; i++) mRegs[i] = '0;
   endtask

   function automatic logic expNInt();
`ifdef VDP_INT_EN
      return !(mF && mRegs[1][5]);
`else
      return 1'b1;
`endif
   endfunction

   task automatic applyStimulus(input bit wr, input bit rd, input bit a0, input logic [7:0] din);
      @(negedge clk);
      bus.cpu_wr = wr; bus.cpu_rd = rd; bus.cpu_a0 = a0; bus.cpu_din = din;
      @(negedge clk);
      bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic doCtrlWrite(input logic [7:0] b);
      if (!mToggle) begin
         mLatch = b; mToggle = 1;
      end else begin
         mToggle = 0;
         if (b[7]) mRegs[b[2:0]] = mLatch;
         else begin
            mAddr = {b[5:0], mLatch};
            if (!b[6]) begin mBuf = refMem[mAddr]; mAddr = mAddr + 14'd1; end
         end
      end
      applyStimulus(1, 0, 1, b);
   endtask

   task automatic doDataWrite(input logic [7:0] b);
      wrQ.push_back('{mAddr, b});
      refMem[mAddr] = b; mBuf = b; mAddr = mAddr + 14'd1; mToggle = 0;
      applyStimulus(1, 0, 0, b);
   endtask

   task automatic doDataRead();
      rdQ.push_back(mBuf);
      mBuf = refMem[mAddr]; mAddr = mAddr + 14'd1; mToggle = 0;
      applyStimulus(0, 1, 0, 8'($urandom));
   endtask

   task automatic doStatusRead();
      rdQ.push_back(mF ? 8'h80 : 8'h00);
      mF = 0; mToggle = 0;
      applyStimulus(0, 1, 1, 8'($urandom));
   endtask

   task automatic doSetup(input logic [13:0] a, input bit forWrite);
      doCtrlWrite(a[7:0]);
      doCtrlWrite({1'b0, forWrite, a[13:8]});
   endtask

   task automatic doRegWrite(input logic [2:0] r, input logic [7:0] v);
      doCtrlWrite(v);
      doCtrlWrite({5'b10000, r});
   endtask

   task automatic doVblank();
`ifdef VDP_INT_EN
      mF = 1;
`endif
      @(negedge clk); bus.vblank_n = 1'b0;
      @(negedge clk); bus.vblank_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic preload(input logic [13:0] a, input logic [7:0] d);
      refMem[a] = d;
      @(negedge clk); preloadEn = 1'b1; preloadAddr = a; preloadData = d;
      @(negedge clk); preloadEn = 1'b0;
   endtask

   task automatic checkVideo();
      logic [1:0] m;
      if (mRegs[1][4]) m = 2'b00;
      else if (mRegs[0][1]) m = 2'b10;
      else m = 2'b01;
      checkOutput("mode", {14'b0, bus.mode}, {14'b0, m});
      checkOutput("video_on", {15'b0, bus.video_on}, {15'b0, mRegs[1][6]});
      checkOutput("name_table_addr", {2'b0, bus.name_table_addr}, {2'b0, mRegs[2][3:0], 10'b0});
      checkOutput("font_addr", {2'b0, bus.font_addr}, {2'b0, mRegs[4][2:0], 11'b0});
      checkOutput("n_int", {15'b0, bus.n_int}, {15'b0, expNInt()});
   endtask

   initial begin
      bus.cpu_wr = 0; bus.cpu_rd = 0; bus.cpu_a0 = 0; bus.cpu_din = 0; bus.vblank_n = 1;
      reset = 1'b1;
      modelReset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("reset cpu_dout", {8'b0, bus.cpu_dout}, 16'h0);
      checkOutput("reset vram_addr", {2'b0, bus.vram_addr}, 16'h0);
      checkOutput("reset vram_dout", {8'b0, bus.vram_dout}, 16'h0);
      checkOutput("reset vram_wr", {15'b0, bus.vram_wr}, 16'h0);
      checkOutput("reset vram_rd", {15'b0, bus.vram_rd}, 16'h0);
      checkOutput("reset busy", {15'b0, bus.busy}, 16'h0);
      checkOutput("reset n_int", {15'b0, bus.n_int}, 16'h1);
      checkOutput("reset mode", {14'b0, bus.mode}, 16'h1);
      checkVideo();

      // Write setup to 0x0000, two writes, then read them back.
      doCtrlWrite(8'h00); doCtrlWrite(8'h40);
      doDataWrite(8'hAA); doDataWrite(8'h55);
      doSetup(14'h0000, 0);
      doDataRead(); doDataRead();

      // Register-derived video outputs.
      doRegWrite(3'd1, 8'h10); checkVideo();
      doRegWrite(3'd0, 8'h02); doRegWrite(3'd1, 8'h00); checkVideo();
      doRegWrite(3'd2, 8'h0F); doRegWrite(3'd4, 8'h07); doRegWrite(3'd1, 8'h40); checkVideo();

      // Read-ahead from a preloaded region.
      preload(14'h1234, 8'h77); preload(14'h1235, 8'h88); preload(14'h1236, 8'h99);
      doCtrlWrite(8'h34); doCtrlWrite(8'h12);
      doDataRead(); doDataRead(); doDataRead();

      // Address wrap at the top of VRAM.
      doSetup(14'h3FFF, 1);
      doDataWrite(8'h11); doDataWrite(8'h22);

      // Frame interrupt and status reads.
      doRegWrite(3'd1, 8'h20);
      doVblank(); checkVideo();
      doStatusRead(); checkVideo();
      doStatusRead();
`ifdef VDP_INT_EN
      // Status read on the same edge as a vblank fall: the flag survives.
      rdQ.push_back(mF ? 8'h80 : 8'h00);
      mF = 1; mToggle = 0;
      @(negedge clk); bus.cpu_rd = 1; bus.cpu_a0 = 1; bus.vblank_n = 0;
      @(negedge clk); bus.cpu_rd = 0; bus.vblank_n = 1;
      repeat (3) @(negedge clk);
      checkVideo();
      doStatusRead();
`endif

      // A data read clears a half-finished control sequence.
      doCtrlWrite(8'h55); doDataRead();
      doCtrlWrite(8'h00); doCtrlWrite(8'h40);
      doDataWrite(8'h33);

      // A write strobe issued while the prefetch is in flight is ignored.
      rdQ.push_back(mBuf);
      mBuf = refMem[mAddr]; mAddr = mAddr + 14'd1; mToggle = 0;
      @(negedge clk); bus.cpu_rd = 1; bus.cpu_a0 = 0;
      @(negedge clk); bus.cpu_rd = 0;
      checkOutput("busy in REQ", {15'b0, bus.busy}, 16'h1);
      checkOutput("vram_rd in REQ", {15'b0, bus.vram_rd}, 16'h1);
      bus.cpu_wr = 1; bus.cpu_din = 8'hEE;
      @(negedge clk); bus.cpu_wr = 0;
      repeat (3) @(negedge clk);
      doDataRead();

      // Randomised traffic.
      for (int n = 0; n < 200; n++) begin
         case ($urandom_range(0, 7))
            0: doCtrlWrite(8'($urandom));
            1: doSetup(14'($urandom), 1);
            2: doSetup(14'($urandom), 0);
            3: doDataWrite(8'($urandom));
            4: doDataRead();
            5: doStatusRead();
            6: begin doRegWrite(3'($urandom), 8'($urandom)); checkVideo(); end
            default: begin doVblank(); checkVideo(); end
         endcase
      end

      // Reset in the middle of a prefetch aborts it and clears the buffer.
      rdQ.push_back(mBuf);
      @(negedge clk); bus.cpu_rd = 1; bus.cpu_a0 = 0;
      @(negedge clk); bus.cpu_rd = 0;
      #2 reset = 1'b1;
      modelReset();
      @(negedge clk);
      checkOutput("busy after reset", {15'b0, bus.busy}, 16'h0);
      checkOutput("vram_rd after reset", {15'b0, bus.vram_rd}, 16'h0);
      reset = 1'b0;
      @(negedge clk);
      doDataRead();
      doDataRead();
      checkVideo();

      repeat (5) @(negedge clk);
      checkOutput("write queue drained", 16'(wrQ.size()), 16'd0);
      checkOutput("read queue drained", 16'(rdQ.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
